// File: rtl/lfsr_stream_if.sv
// Stream/control bundle for lfsr_stream: seed load, run control, and the valid/ready PRBS output.
interface lfsr_stream_if #(
   parameter int unsigned WIDTH = 4
);
   logic             load;
   logic [WIDTH-1:0] seed;
   logic             start;
   logic             stop;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             wrap;
   logic             lockup;

   modport master (
      output load, seed, start, stop, out_ready,
      input  out_valid, out_data, wrap, lockup
   );

   modport slave (
      input  load, seed, start, stop, out_ready,
      output out_valid, out_data, wrap, lockup
   );
endinterface

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR PRBS source with loadable seed, run/idle FSM and valid/ready output stream.
// Optional all-zero lock-up recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_stream #(
   parameter int unsigned      WIDTH        = 4,
   parameter logic [WIDTH-1:0] TAPS         = 4'b0011,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = 4'b0001
) (
   input logic          clk,
   input logic          rst,
   lfsr_stream_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   fsm_t             fsm_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] seed_r;
   logic             wrap_r;
   logic             xfer_s;
   logic [WIDTH-1:0] step_s;

   // Shift right, parity of the tapped bits enters at the MSB.
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return {^(s & TAPS), s[WIDTH-1:1]};
   endfunction

   assign xfer_s = out_valid_r & bus.out_ready;
   assign step_s = lfsr_next(state_r);

   // Run/idle control; out_valid is registered alongside the state so it mirrors RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_r       <= IDLE;
         out_valid_r <= 1'b0;
      end else begin
         case (fsm_r)
            IDLE: begin
               if (bus.start && !bus.stop) begin
                  fsm_r       <= RUN;
                  out_valid_r <= 1'b1;
               end else begin
                  fsm_r       <= IDLE;
                  out_valid_r <= 1'b0;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  fsm_r       <= IDLE;
                  out_valid_r <= 1'b0;
               end else begin
                  fsm_r       <= RUN;
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               fsm_r       <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef LFSR_LOCKUP_RECOVER_EN
   logic lockup_r;

   // LFSR state, seed register and wrap pulse; load beats recovery, recovery beats a step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= SEED_DEFAULT;
         seed_r   <= SEED_DEFAULT;
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;
      end else if (bus.load) begin
         state_r <= bus.seed;
         seed_r  <= bus.seed;
         wrap_r  <= 1'b0;
      end else if (state_r == {WIDTH{1'b0}}) begin
         // The word on the bus this cycle is discarded; no step is taken.
         state_r  <= SEED_DEFAULT;
         wrap_r   <= 1'b0;
         lockup_r <= 1'b1;
      end else if (xfer_s) begin
         state_r <= step_s;
         wrap_r  <= (step_s == seed_r);
      end else begin
         wrap_r <= 1'b0;
      end
   end

   assign bus.lockup = lockup_r;
`else
   // LFSR state, seed register and wrap pulse; load has priority over a step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= SEED_DEFAULT;
         seed_r  <= SEED_DEFAULT;
         wrap_r  <= 1'b0;
      end else if (bus.load) begin
         state_r <= bus.seed;
         seed_r  <= bus.seed;
         wrap_r  <= 1'b0;
      end else if (xfer_s) begin
         state_r <= step_s;
         wrap_r  <= (step_s == seed_r);
      end else begin
         wrap_r <= 1'b0;
      end
   end

   assign bus.lockup = 1'b0;
`endif

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = state_r;
   assign bus.wrap      = wrap_r;

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: directed scenarios plus a randomized run against a reference model.
module tb_lfsr_stream;
   localparam int unsigned W    = 4;
   localparam logic [3:0]  TAPS = 4'b0011;
   localparam logic [3:0]  SD   = 4'b0001;

   logic clk = 1'b0;
   logic rst;

   lfsr_stream_if #(.WIDTH(W)) bus ();

   lfsr_stream #(.WIDTH(W), .TAPS(TAPS), .SEED_DEFAULT(SD)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // reference model state
   logic [3:0] m_state;
   logic [3:0] m_seed;
   logic       m_run;
   logic       m_wrap;
   logic       m_lock;

   logic [3:0] seq2 [0:15];

   function automatic logic [3:0] ref_next(input logic [3:0] s);
      int fb;
      fb = $countones(s & TAPS) % 2;
      return 4'((fb << (W - 1)) | int'(s >> 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = SD;
      m_seed  = SD;
      m_run   = 1'b0;
      m_wrap  = 1'b0;
      m_lock  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":valid"}, 32'(bus.out_valid), 32'(m_run));
      chk({tag, ":data"},  32'(bus.out_data),  32'(m_state));
      chk({tag, ":wrap"},  32'(bus.wrap),      32'(m_wrap));
      chk({tag, ":lock"},  32'(bus.lockup),    32'(m_lock));
   endtask

   // One clock: predict from the inputs in force, then compare after the edge.
   task automatic tick(input string tag);
      logic [3:0] ns;
      logic [3:0] nsd;
      logic       nr;
      logic       nw;
      logic       nl;
      ns  = m_state;
      nsd = m_seed;
      nw  = 1'b0;
      nl  = m_lock;
      if (bus.load) begin
         ns  = bus.seed;
         nsd = bus.seed;
      end
`ifdef LFSR_LOCKUP_RECOVER_EN
      else if (m_state == 4'd0) begin
         ns = SD;
         nl = 1'b1;
      end
`endif
      else if (m_run && bus.out_ready) begin
         ns = ref_next(m_state);
         nw = (ns == m_seed);
      end
      if (m_run) nr = !bus.stop;
      else       nr = bus.start && !bus.stop;
      @(posedge clk);
      #1;
      m_state = ns;
      m_seed  = nsd;
      m_run   = nr;
      m_wrap  = nw;
      m_lock  = nl;
      check_all(tag);
   endtask

   initial begin
      seq2 = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101,
               4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000};
      rst           = 1'b1;
      bus.load      = 1'b0;
      bus.seed      = 4'b0000;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst = 1'b0;

      // 1: async reset while running
      bus.load  = 1'b1;
      bus.seed  = 4'b1000;
      bus.start = 1'b1;
      tick("t1_load");
      bus.load      = 1'b0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick("t1_run");
      #3;
      rst = 1'b1;
      #1;
      chk("t1_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("t1_rst_data",  32'(bus.out_data),  32'h1);
      chk("t1_rst_wrap",  32'(bus.wrap),      32'd0);
      chk("t1_rst_lock",  32'(bus.lockup),    32'd0);
      model_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick("t1_idle");
      chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);

      // 2: full period from seed 1000
      bus.load      = 1'b1;
      bus.seed      = 4'b1000;
      bus.start     = 1'b1;
      bus.out_ready = 1'b0;
      tick("t2_load");
      chk("t2_first", 32'(bus.out_data), 32'(seq2[0]));
      bus.load      = 1'b0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         tick("t2_step");
         chk("t2_seq",  32'(bus.out_data), 32'(seq2[i]));
         chk("t2_wrap", 32'(bus.wrap),     32'(i == 15));
      end

      // 3: backpressure holds the word
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("t3_hold");
         chk("t3_hold_data", 32'(bus.out_data), 32'h8);
      end
      bus.out_ready = 1'b1;
      tick("t3_resume");
      chk("t3_resume_data", 32'(bus.out_data), 32'h4);

      // 4: stop with a transfer, then idle behaviour
      bus.stop = 1'b1;
      tick("t4_stop");
      chk("t4_stop_data", 32'(bus.out_data), 32'h2);
      chk("t4_stop_valid", 32'(bus.out_valid), 32'd0);
      bus.stop = 1'b0;
      tick("t4_frozen");
      chk("t4_frozen_data", 32'(bus.out_data), 32'h2);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick("t4_both");
      chk("t4_both_valid", 32'(bus.out_valid), 32'd0);
      bus.stop = 1'b0;
      tick("t4_start");
      chk("t4_start_valid", 32'(bus.out_valid), 32'd1);
      bus.start = 1'b0;

      // 5: load while streaming
      tick("t5_pre");
      chk("t5_pre_data", 32'(bus.out_data), 32'h9);
      bus.load = 1'b1;
      bus.seed = 4'b0110;
      tick("t5_load");
      chk("t5_load_data", 32'(bus.out_data), 32'h6);
      chk("t5_load_wrap", 32'(bus.wrap), 32'd0);
      bus.load = 1'b0;
      tick("t5_next");
      chk("t5_next_data", 32'(bus.out_data), 32'hB);
      chk("t5_next_wrap", 32'(bus.wrap), 32'd0);

      // 6: zero seed
      bus.load = 1'b1;
      bus.seed = 4'b0000;
      tick("t6_load");
      bus.load = 1'b0;
      tick("t6_after");
`ifdef LFSR_LOCKUP_RECOVER_EN
      chk("t6_data", 32'(bus.out_data), 32'h1);
      chk("t6_lock", 32'(bus.lockup),   32'd1);
`else
      chk("t6_data", 32'(bus.out_data), 32'h0);
      chk("t6_lock", 32'(bus.lockup),   32'd0);
      chk("t6_wrap", 32'(bus.wrap),     32'd1);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         bus.load      = ($urandom_range(0, 15) == 0);
         bus.seed      = 4'($urandom_range(1, 15));
         bus.start     = ($urandom_range(0, 7) == 0);
         bus.stop      = ($urandom_range(0, 15) == 0);
         bus.out_ready = 1'($urandom);
         tick("rnd");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
